// File: rtl/tree_dispatch_sched_if.sv
// Packet stream interface: val/sop/eop/dat/ctl/err/mod forward, rdy backward.
// source/master drive the forward fields; sink/slave drive rdy.
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8
);
    localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    logic                  val;
    logic                  sop;
    logic                  eop;
    logic [DAT_BYTS*8-1:0] dat;
    logic [CTL_BITS-1:0]   ctl;
    logic                  err;
    logic [MOD_BITS-1:0]   mod;
    logic                  rdy;

    modport source (output val, sop, eop, dat, ctl, err, mod, input rdy);
    modport sink   (input val, sop, eop, dat, ctl, err, mod, output rdy);
    modport master (output val, sop, eop, dat, ctl, err, mod, input rdy);
    modport slave  (input val, sop, eop, dat, ctl, err, mod, output rdy);
endinterface

// File: rtl/tree_dispatch_sched.sv
// Credit-based dispatcher: picks a core round-robin among those below
// MAX_OUT outstanding jobs, stamps its index into ctl and forwards the packet.
// Optional statistics counters: define TREE_DISPATCH_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a sop; choose a core, stall if none is eligible
// XFER  | packet passes through combinationally with ctl index overwritten
module tree_dispatch_sched #(
    parameter int DAT_BYTS    = 8,
    parameter int CTL_BITS    = 8,
    parameter int NUM_OUT     = 8,
    parameter int MAX_OUT     = 2,
    parameter int OVR_WRT_BIT = 0,
    localparam int IDX_W      = $clog2(NUM_OUT)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    if_axi_stream.sink         i_axi,
    if_axi_stream.source       o_axi,
    input  logic               i_done_val,
    input  logic [IDX_W-1:0]   i_done_idx,
    output logic [NUM_OUT-1:0] o_busy,
    output logic               o_err
`ifdef TREE_DISPATCH_SCHED_STATS_EN
    ,
    output logic [31:0]        o_pkt_cnt,
    output logic [31:0]        o_stall_cnt
`endif
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t             state, state_nxt;
    logic [3:0]         credit [NUM_OUT];
    logic [IDX_W-1:0]   rr, sel, pick;
    logic               pick_ok;
    logic [NUM_OUT-1:0] dec_vec, inc_vec, elig;
    logic               done_bad, grant, acc_sop, drop;

    // Decode the completion strobe; bad index or zero credit is an error
    always_comb begin
        dec_vec  = '0;
        done_bad = 1'b0;
        if (i_done_val) begin
            if ({1'b0, i_done_idx} >= (IDX_W+1)'(NUM_OUT)) begin
                done_bad = 1'b1;
            end else begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (i_done_idx == IDX_W'(k)) begin
                        if (credit[k] == 4'd0) done_bad = 1'b1;
                        else                   dec_vec[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Eligibility uses credits after this cycle's completion; scan from rr+1
    always_comb begin : pick_blk
        int j;
        pick    = rr;
        pick_ok = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            elig[k] = (credit[k] - {3'b000, dec_vec[k]}) < 4'(MAX_OUT);
        end
        for (int i = 1; i <= NUM_OUT; i++) begin
            j = (int'(rr) + i) % NUM_OUT;
            if (!pick_ok && elig[j]) begin
                pick_ok = 1'b1;
                pick    = IDX_W'(j);
            end
        end
    end

    // Next state, handshake and pass-through datapath
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        acc_sop   = 1'b0;
        drop      = 1'b0;
        i_axi.rdy = 1'b0;
        o_axi.val = 1'b0;
        o_axi.sop = i_axi.sop;
        o_axi.eop = i_axi.eop;
        o_axi.dat = i_axi.dat;
        o_axi.err = i_axi.err;
        o_axi.mod = i_axi.mod;
        o_axi.ctl = i_axi.ctl;
        o_axi.ctl[OVR_WRT_BIT +: IDX_W] = sel;
        case (state)
            IDLE: begin
                if (i_axi.val) begin
                    if (i_axi.sop) begin
                        if (pick_ok) begin
                            grant     = 1'b1;
                            state_nxt = XFER;
                        end
                    end else begin
                        // stray mid-packet beat: swallow it and flag
                        i_axi.rdy = 1'b1;
                        drop      = 1'b1;
                    end
                end
            end
            XFER: begin
                o_axi.val = i_axi.val;
                i_axi.rdy = o_axi.rdy;
                if (i_axi.val && o_axi.rdy) begin
                    acc_sop = i_axi.sop;
                    if (i_axi.eop) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Credit increment targets the latched core
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            inc_vec[k] = acc_sop && (sel == IDX_W'(k));
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Round-robin pointer and selected core latch on grant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr  <= IDX_W'(NUM_OUT - 1);
            sel <= '0;
        end else if (grant) begin
            rr  <= pick;
            sel <= pick;
        end
    end

    // Per-core credits; simultaneous inc and dec cancel
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_OUT; k++) begin
            if (i_rst)                          credit[k] <= 4'd0;
            else if (inc_vec[k] && !dec_vec[k]) credit[k] <= credit[k] + 4'd1;
            else if (dec_vec[k] && !inc_vec[k]) credit[k] <= credit[k] - 4'd1;
        end
    end

    // Busy flags follow the credit registers by one cycle
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_OUT; k++) begin
            if (i_rst) o_busy[k] <= 1'b0;
            else       o_busy[k] <= (credit[k] == 4'(MAX_OUT));
        end
    end

    // Sticky error, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst)                 o_err <= 1'b0;
        else if (done_bad || drop) o_err <= 1'b1;
    end

`ifdef TREE_DISPATCH_SCHED_STATS_EN
    logic stall;
    assign stall = (state == IDLE) && i_axi.val && i_axi.sop && !pick_ok;

    // Saturating statistics counters; observe only, never steer scheduling
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pkt_cnt   <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (acc_sop && o_pkt_cnt != '1)   o_pkt_cnt   <= o_pkt_cnt + 32'd1;
            if (stall && o_stall_cnt != '1)   o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif
endmodule
